// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter and load sequencer for one shared DW-bit register
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req, lock    per-requester load request and burst-hold request
//   din          packed requester data, slice i = din[i*DW +: DW]
//   gnt, ack     one-hot registered grant, load strobe for the preceding edge
//   q, busy      shared register contents, arbiter not idle
module reg_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]   gnt,
  output logic               ack,
  output logic [DW-1:0]      q,
  output logic               busy
);
  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              ack_q, ack_d;
  logic [DW-1:0]     data_q, data_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [PW-1:0]     win, idx;
  logic              found;
  // first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d   = N_REQ'(1) << win;
          data_d  = din[int'(win)*DW +: DW];
          ack_d   = 1'b1;
          ptr_d   = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
          owner_d = win;
          hold_d  = HW'(1);
          state_d = (lock[win] && MAX_HOLD >= 2) ? LOCK : GRANT;
        end
      end
      LOCK: begin
        if (req[owner_q] && lock[owner_q] && hold_q < HW'(MAX_HOLD)) begin
          data_d = din[int'(owner_q)*DW +: DW];
          ack_d  = 1'b1;
          hold_d = hold_q + HW'(1);
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end
  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign q    = data_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed self-checking bench for reg_share_arbiter
module tb_reg_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, lock, gnt;
  logic [31:0] din;
  logic        ack, busy;
  logic [7:0]  q;
  int          passed = 0;
  int          total = 0;
  logic [3:0]  rr_exp [9];
  reg_share_arbiter #(.N_REQ(4), .DW(8), .MAX_HOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .din(din),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_din(input int i, input logic [7:0] v);
    din[i*8 +: 8] = v;
  endtask
  task automatic chk_all(input string tag, input logic [3:0] g, input logic a, input logic [7:0] d, input logic b);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".q"}, 32'(q), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask
  initial begin
    rst_n = 1'b0; req = '0; lock = '0; din = '0;
    #1;
    chk_all("reset", 4'b0000, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("idle", 4'b0000, 1'b0, 8'h00, 1'b0);
    // single request
    req = 4'b0100; set_din(2, 8'hA5);
    tick();
    chk_all("single.e1", 4'b0100, 1'b1, 8'hA5, 1'b1);
    req = 4'b0000;
    tick();
    chk_all("single.e2", 4'b0000, 1'b0, 8'hA5, 1'b0);
    // reset pulse between edges, then round robin from ptr=0
    #1 rst_n = 1'b0;
    #1 chk_all("rst2", 4'b0000, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    din = 32'hD3C2B1A0; req = 4'b1111;
    rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr.gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
      chk($sformatf("rr.ack%0d", i), 32'(ack), 32'(i % 2 == 0));
    end
    chk("rr.q", 32'(q), 32'h000000A0);
    req = 4'b0000;
    tick();
    chk("rr.idle", 32'(gnt), 32'h0);
    // lock cap of three beats
    req = 4'b0010; lock = 4'b0010; set_din(1, 8'h11);
    tick();
    chk_all("cap.b1", 4'b0010, 1'b1, 8'h11, 1'b1);
    set_din(1, 8'h22);
    tick();
    chk_all("cap.b2", 4'b0010, 1'b1, 8'h22, 1'b1);
    set_din(1, 8'h33);
    tick();
    chk_all("cap.b3", 4'b0010, 1'b1, 8'h33, 1'b1);
    set_din(1, 8'h44);
    tick();
    chk_all("cap.end", 4'b0000, 1'b0, 8'h33, 1'b0);
    set_din(1, 8'h55);
    tick();
    chk_all("cap.regrant", 4'b0010, 1'b1, 8'h55, 1'b1);
    req = 4'b0000; lock = 4'b0000;
    tick();
    chk_all("cap.drop", 4'b0000, 1'b0, 8'h55, 1'b0);
    // early release of lock
    req = 4'b0001; lock = 4'b0001; set_din(0, 8'h61);
    tick();
    chk_all("early.b1", 4'b0001, 1'b1, 8'h61, 1'b1);
    set_din(0, 8'h62);
    tick();
    chk_all("early.b2", 4'b0001, 1'b1, 8'h62, 1'b1);
    lock = 4'b0000; set_din(0, 8'h63);
    tick();
    chk_all("early.end", 4'b0000, 1'b0, 8'h62, 1'b0);
    req = 4'b0011;
    tick();
    chk_all("early.next", 4'b0010, 1'b1, 8'h55, 1'b1);
    req = 4'b0000;
    tick();
    chk("early.idle", 32'(busy), 32'h0);
    // contention during a lock burst
    req = 4'b0001; lock = 4'b0001; set_din(0, 8'h71);
    tick();
    chk_all("cont.b1", 4'b0001, 1'b1, 8'h71, 1'b1);
    req = 4'b1001; set_din(3, 8'h99); set_din(0, 8'h72);
    tick();
    chk_all("cont.b2", 4'b0001, 1'b1, 8'h72, 1'b1);
    set_din(0, 8'h73);
    tick();
    chk_all("cont.b3", 4'b0001, 1'b1, 8'h73, 1'b1);
    tick();
    chk_all("cont.end", 4'b0000, 1'b0, 8'h73, 1'b0);
    tick();
    chk_all("cont.next", 4'b1000, 1'b1, 8'h99, 1'b1);
    req = 4'b0000; lock = 4'b0000;
    tick();
    // async reset in the middle of a lock burst
    req = 4'b0010; lock = 4'b0010; set_din(1, 8'hAA);
    tick();
    chk_all("arst.b1", 4'b0010, 1'b1, 8'hAA, 1'b1);
    tick();
    chk("arst.b2", 32'(ack), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all("arst.now", 4'b0000, 1'b0, 8'h00, 1'b0);
    req = 4'b1001; lock = 4'b0000; set_din(0, 8'h5C);
    #1 rst_n = 1'b1;
    tick();
    chk_all("arst.first", 4'b0001, 1'b1, 8'h5C, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
